// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// fault cause encodings and the branch opcodes the fetch stage recognises.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  localparam logic [10:0] OP_B  = 11'b00000000101;
  localparam logic [10:0] OP_BL = 11'b00000100101;

  // Instruction words are 4-byte aligned; any set low bit is a bad target.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel: the fetch unit drives the request side
// (master), the memory answers with rvalid/rdata (slave).
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Cycle counter for an outstanding fetch; expired is high while the count
// sits at TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES must be at least 2).
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory and hands each word to
// decode. Define BRANCH_LINK_EN to add the BL link-register write port.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master imem,
  output logic [31:0]        instruction,
  output logic [ADDR_W-1:0]  program_counter,
  input  logic [ADDR_W-1:0]  program_counter_next,
  output logic               inst_valid,
  input  logic               stall,
  output logic               fetch_fault,
  output logic [1:0]         fault_cause
`ifdef BRANCH_LINK_EN
  ,
  output logic               link_we,
  output logic [ADDR_W-1:0]  link_data
`endif
);

  fetch_state_e state;
  logic         tmo_expired;
  logic         tmo_clear;
  logic         in_fetch;
  logic         issue_go;

  assign in_fetch       = (state == FETCH);
  assign tmo_clear      = !in_fetch || imem.imem_rvalid;
  assign issue_go       = (state == ISSUE) && !stall;
  assign imem.imem_addr = program_counter;

  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .en      (in_fetch),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= BOOT;
      program_counter <= RESET_PC;
      instruction     <= '0;
      inst_valid      <= 1'b0;
      imem.imem_req   <= 1'b0;
      fetch_fault     <= 1'b0;
      fault_cause     <= FAULT_NONE;
    end else begin
      // NOTE: every case arm either assigns or holds; a register simply keeps
      // its value, so no default assignments are needed in a clocked block.
      case (state)
        BOOT: begin
          state         <= FETCH;
          imem.imem_req <= 1'b1;
        end
        FETCH: begin
          // A response in the expiry cycle still wins over the timeout.
          if (imem.imem_rvalid) begin
            instruction   <= imem.imem_rdata;
            inst_valid    <= 1'b1;
            imem.imem_req <= 1'b0;
            state         <= ISSUE;
          end else if (tmo_expired) begin
            imem.imem_req <= 1'b0;
            fetch_fault   <= 1'b1;
            fault_cause   <= FAULT_TIMEOUT;
            state         <= FAULT;
          end
        end
        ISSUE: begin
          if (issue_go) begin
            inst_valid <= 1'b0;
            if (is_word_aligned(program_counter_next[1:0])) begin
              program_counter <= program_counter_next;
              imem.imem_req   <= 1'b1;
              state           <= FETCH;
            end else begin
              fetch_fault <= 1'b1;
              fault_cause <= FAULT_MISALIGN;
              state       <= FAULT;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

`ifdef BRANCH_LINK_EN
  logic bl_taken;

  // Link write fires on the cycle after a BL leaves ISSUE for the next fetch.
  assign bl_taken = issue_go && is_word_aligned(program_counter_next[1:0])
                 && (instruction[31:21] == OP_BL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      link_we   <= 1'b0;
      link_data <= '0;
    end else if (bl_taken) begin
      link_we   <= 1'b1;
      link_data <= program_counter + ADDR_W'(4);
    end else begin
      link_we   <= 1'b0;
      link_data <= '0;
    end
  end
`endif

endmodule
